// File: rtl/score_digits_if.sv
// Signal bundle between the score keeper and its surroundings.
// The master side drives the point/frame/clear requests and reads the glyphs and score.
// The score keeper connects through the slave side.
interface score_digits_if;
    logic       Point;
    logic       FrameStart;
    logic       Clear;
    logic [8:0] Tens0, Tens1, Tens2, Tens3;
    logic [8:0] Ones0, Ones1, Ones2, Ones3;
    logic [7:0] ScoreBCD;
    logic       Win;

    modport master (
        output Point, FrameStart, Clear,
        input  Tens0, Tens1, Tens2, Tens3,
        input  Ones0, Ones1, Ones2, Ones3,
        input  ScoreBCD, Win
    );

    modport slave (
        input  Point, FrameStart, Clear,
        output Tens0, Tens1, Tens2, Tens3,
        output Ones0, Ones1, Ones2, Ones3,
        output ScoreBCD, Win
    );
endinterface

// File: rtl/score_digits.sv
// Two-digit BCD score keeper with a frame-synchronous glyph generator.
// Points are edge-detected and limited to one per frame. The score stops at WIN_SCORE.
// The glyph shadow registers reload only on FrameStart, so a digit never tears mid-frame.
// After a win the glyphs blink every BLINK_FRAMES frames.
module score_digits #(
    parameter int WIN_SCORE     = 11,
    parameter int BLINK_FRAMES  = 32,
    parameter int LEADING_BLANK = 1
) (
    input  logic           clk,
    input  logic           reset,
    score_digits_if.slave  bus
);
    localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
    localparam int         CNT_W   = (BLINK_FRAMES < 2) ? 1 : $clog2(BLINK_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (BLINK_FRAMES == 0) ? '0 : CNT_W'(BLINK_FRAMES - 1);

    typedef enum logic { PLAY, WON } state_t;

    // Four 9-bit columns packed as {col3, col2, col1, col0}; col0 is the leftmost column.
    function automatic logic [35:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    return {9'h1FF, 9'h101, 9'h101, 9'h1FF};
            4'd1:    return {9'h100, 9'h1FF, 9'h102, 9'h000};
            4'd2:    return {9'h11F, 9'h111, 9'h111, 9'h1F1};
            4'd3:    return {9'h1FF, 9'h111, 9'h111, 9'h111};
            4'd4:    return {9'h1FF, 9'h010, 9'h010, 9'h01F};
            4'd5:    return {9'h1F1, 9'h111, 9'h111, 9'h11F};
            4'd6:    return {9'h1F1, 9'h111, 9'h111, 9'h1FF};
            4'd7:    return {9'h1FF, 9'h001, 9'h001, 9'h001};
            4'd8:    return {9'h1FF, 9'h111, 9'h111, 9'h1FF};
            4'd9:    return {9'h1FF, 9'h111, 9'h111, 9'h11F};
            default: return 36'd0;
        endcase
    endfunction

    localparam logic [35:0] ONES_RST = glyph(4'd0);
    localparam logic [35:0] TENS_RST = (LEADING_BLANK != 0) ? 36'd0 : glyph(4'd0);

    state_t           r_state;
    logic             r_win;
    logic [7:0]       r_score;
    logic             r_lockout;
    logic             r_blank;
    logic [CNT_W-1:0] r_cnt;
    logic             r_point_q;
    logic [35:0]      r_tens;
    logic [35:0]      r_ones;

    logic             w_rise;
    logic             w_accept;
    logic [7:0]       w_inc;
    logic             w_inc_win;
    logic [35:0]      w_tens_glyph;
    logic [35:0]      w_ones_glyph;

    assign w_rise    = bus.Point & ~r_point_q;
    assign w_accept  = w_rise & (r_state == PLAY) & ~r_lockout & ~bus.Clear;
    // Tens can never wrap: WIN_SCORE <= 99 stops counting before 99 -> 100.
    assign w_inc     = (r_score[3:0] == 4'd9) ? {r_score[7:4] + 4'd1, 4'd0}
                                              : {r_score[7:4], r_score[3:0] + 4'd1};
    assign w_inc_win = (w_inc == WIN_BCD);

    assign w_ones_glyph = glyph(r_score[3:0]);
    assign w_tens_glyph = ((LEADING_BLANK != 0) && (r_score[7:4] == 4'd0)) ? 36'd0
                                                                          : glyph(r_score[7:4]);

    // Score, win state, per-frame lockout and blink timing.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= PLAY;
            r_win     <= 1'b0;
            r_score   <= 8'h00;
            r_lockout <= 1'b0;
            r_blank   <= 1'b0;
            r_cnt     <= '0;
            r_point_q <= 1'b0;
        end else begin
            r_point_q <= bus.Point;
            if (bus.Clear) begin
                r_state   <= PLAY;
                r_win     <= 1'b0;
                r_score   <= 8'h00;
                r_lockout <= 1'b0;
                r_blank   <= 1'b0;
                r_cnt     <= '0;
            end else begin
                if (w_accept) begin
                    r_score   <= w_inc;
                    r_lockout <= 1'b1;
                    if (w_inc_win) begin
                        r_state <= WON;
                        r_win   <= 1'b1;
                        r_cnt   <= '0;
                        r_blank <= 1'b0;
                    end
                end else if (bus.FrameStart) begin
                    r_lockout <= 1'b0;
                end
                // Points are never accepted in WON, so this cannot collide with win entry.
                if ((r_state == WON) && bus.FrameStart && (BLINK_FRAMES != 0)) begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_blank <= ~r_blank;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Glyph shadow registers reload from the pre-update score on each FrameStart.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tens <= TENS_RST;
            r_ones <= ONES_RST;
        end else if (bus.FrameStart) begin
            if (r_blank) begin
                r_tens <= 36'd0;
                r_ones <= 36'd0;
            end else begin
                r_tens <= w_tens_glyph;
                r_ones <= w_ones_glyph;
            end
        end
    end

    assign bus.ScoreBCD = r_score;
    assign bus.Win      = r_win;
    assign bus.Tens0    = r_tens[8:0];
    assign bus.Tens1    = r_tens[17:9];
    assign bus.Tens2    = r_tens[26:18];
    assign bus.Tens3    = r_tens[35:27];
    assign bus.Ones0    = r_ones[8:0];
    assign bus.Ones1    = r_ones[17:9];
    assign bus.Ones2    = r_ones[26:18];
    assign bus.Ones3    = r_ones[35:27];
endmodule

// File: tb/tb_score_digits.sv
// Bench for score_digits: directed scenarios followed by random point/frame/clear traffic.
// A game-level model predicts every cycle's outputs into a queue that a monitor drains.
module tb_score_digits;
    localparam int WIN   = 11;
    localparam int BLINK = 2;
    localparam int LB    = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    score_digits_if ifc();

    score_digits #(.WIN_SCORE(WIN), .BLINK_FRAMES(BLINK), .LEADING_BLANK(LB)) dut (
        .clk(clk),
        .reset(reset),
        .bus(ifc)
    );

    typedef struct packed {
        logic [7:0]  bcd;
        logic        win;
        logic [35:0] tens;
        logic [35:0] ones;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [8:0] font [10][4] = '{
        '{9'h1FF, 9'h101, 9'h101, 9'h1FF},
        '{9'h000, 9'h102, 9'h1FF, 9'h100},
        '{9'h1F1, 9'h111, 9'h111, 9'h11F},
        '{9'h111, 9'h111, 9'h111, 9'h1FF},
        '{9'h01F, 9'h010, 9'h010, 9'h1FF},
        '{9'h11F, 9'h111, 9'h111, 9'h1F1},
        '{9'h1FF, 9'h111, 9'h111, 9'h1F1},
        '{9'h001, 9'h001, 9'h001, 9'h1FF},
        '{9'h1FF, 9'h111, 9'h111, 9'h1FF},
        '{9'h11F, 9'h111, 9'h111, 9'h1FF}
    };

    // Game model: decimal score, won flag, one-point-per-frame lockout, blink and displayed value.
    int m_score, m_pq, m_won, m_lock, m_blank, m_frames, m_disp, m_dblank;

    function automatic logic [35:0] glyph_of(input int d);
        return {font[d][3], font[d][2], font[d][1], font[d][0]};
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        e.bcd  = {4'(m_score / 10), 4'(m_score % 10)};
        e.win  = (m_won != 0);
        e.ones = (m_dblank != 0) ? 36'd0 : glyph_of(m_disp % 10);
        e.tens = ((m_dblank != 0) || (LB != 0 && m_disp / 10 == 0)) ? 36'd0 : glyph_of(m_disp / 10);
        return e;
    endfunction

    task automatic model_reset();
        m_score = 0; m_pq = 0; m_won = 0; m_lock = 0;
        m_blank = 0; m_frames = 0; m_disp = 0; m_dblank = 0;
    endtask

    task automatic model_step(input logic r, input logic p, input logic f, input logic c);
        bit rise;
        bit take;
        if (r) begin
            model_reset();
            return;
        end
        rise = p && (m_pq == 0);
        if (f) begin
            m_dblank = m_blank;
            m_disp   = m_score;
        end
        take = rise && (m_won == 0) && (m_lock == 0) && !c;
        if (c) begin
            m_score = 0; m_won = 0; m_lock = 0; m_blank = 0; m_frames = 0;
        end else begin
            if (m_won != 0 && f && BLINK != 0) begin
                m_frames++;
                if (m_frames == BLINK) begin
                    m_frames = 0;
                    m_blank  = !m_blank;
                end
            end
            if (take) begin
                m_score++;
                m_lock = 1;
                if (m_score == WIN) begin
                    m_won = 1; m_frames = 0; m_blank = 0;
                end
            end else if (f) begin
                m_lock = 0;
            end
        end
        m_pq = p;
    endtask

    // Drive one cycle of inputs and queue the outputs expected after its clock edge.
    task automatic cycle(input logic r, input logic p, input logic f, input logic c);
        @(negedge clk);
        reset          = r;
        ifc.Point      = p;
        ifc.FrameStart = f;
        ifc.Clear      = c;
        model_step(r, p, f, c);
        q.push_back(expect_now());
    endtask

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, req);
        end
    endtask

    // Monitor: one expectation per clock edge, sampled just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("ScoreBCD", 36'(ifc.ScoreBCD), 36'(e.bcd));
            chk("Win", 36'(ifc.Win), 36'(e.win));
            chk("Tens", {ifc.Tens3, ifc.Tens2, ifc.Tens1, ifc.Tens0}, e.tens);
            chk("Ones", {ifc.Ones3, ifc.Ones2, ifc.Ones1, ifc.Ones0}, e.ones);
        end
    end

    // Score one point with a clean pulse, then close the frame.
    task automatic point_then_frame();
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
    endtask

    initial begin
        logic p;
        int   fcnt;
        ifc.Point = 1'b0;
        ifc.FrameStart = 1'b0;
        ifc.Clear = 1'b0;
        model_reset();

        repeat (3) cycle(1, 0, 0, 0);
        // Single pulse then frame.
        point_then_frame();
        // Point held for 100 cycles across three frames counts once.
        for (int i = 0; i < 100; i++) cycle(0, 1, (i % 30) == 10, 0);
        cycle(0, 0, 1, 0);
        // Clear, then count up to 10 and show it.
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) point_then_frame();
        // Win at 11, further points ignored, blink.
        point_then_frame();
        point_then_frame();
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 1, 0);
            cycle(0, 0, 0, 0);
        end
        // Clear with simultaneous rising point, from 05.
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) point_then_frame();
        cycle(0, 1, 0, 1);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        // Point rising together with FrameStart at 03.
        for (int i = 0; i < 3; i++) point_then_frame();
        cycle(0, 1, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        // Mid-operation reset.
        cycle(0, 1, 0, 0);
        cycle(1, 1, 1, 0);
        cycle(0, 1, 0, 0);

        // Random traffic.
        p = 1'b0;
        fcnt = 4;
        for (int i = 0; i < 8000; i++) begin
            logic f, c, r;
            if ($urandom_range(0, 2) == 0) p = ~p;
            f = (fcnt == 0);
            fcnt = f ? $urandom_range(2, 9) : fcnt - 1;
            c = ($urandom_range(0, 499) == 0);
            r = ($urandom_range(0, 2999) == 0);
            cycle(r, p, f, c);
        end

        repeat (3) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/score_digits.md
# score_digits

Two-digit score keeper and glyph generator for one player. It counts point events in BCD and detects the win score. It produces the 4x9 column bitmaps for the tens and ones digits, which feed the Matrix0..Matrix3 inputs of two downstream matrix-display instances. Glyph outputs change only at frame boundaries so a digit never tears mid-frame, and they blink after a win.

## Interface
- WIN_SCORE, default 11: winning score, decimal, legal range 1..99.
- BLINK_FRAMES, default 32: frames per blink half-period in WON; 0 disables blink.
- LEADING_BLANK, default 1: 1 = tens glyph is all-zero when the tens digit is 0.
- clk  in  1  system clock; one clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- Point  in  1  level from collision logic; each rising edge is one point request.
- FrameStart  in  1  one-cycle pulse at the start of each video frame.
- Clear  in  1  synchronous new-game request; returns score to 00.
- Tens0..Tens3  out  9 each  tens-digit columns, left to right; bit 0 = top row, bit 8 = bottom row.
- Ones0..Ones3  out  9 each  ones-digit columns, same encoding.
- ScoreBCD  out  8  live score; [7:4] tens, [3:0] ones.
- Win  out  1  high while in WON.

## Operation
- Font, columns 0..3 in hex:
  - 0: 1FF,101,101,1FF
  - 1: 000,102,1FF,100
  - 2: 1F1,111,111,11F
  - 3: 111,111,111,1FF
  - 4: 01F,010,010,1FF
  - 5: 11F,111,111,1F1
  - 6: 1FF,111,111,1F1
  - 7: 001,001,001,1FF
  - 8: 1FF,111,111,1FF
  - 9: 11F,111,111,1FF
- States are PLAY and WON.
- Edge detect: a registered copy of Point gives rise = Point & ~Point_q.
- Lockout flag limits scoring to one point per frame:
  - A point is accepted when rise, state is PLAY, lockout = 0 and Clear = 0.
  - Accept sets lockout.
  - Otherwise FrameStart clears lockout.
  - If accept and FrameStart occur together, lockout ends set.
- Increment is BCD: ones 9 -> 0 with tens +1. Tens never exceeds 9 because WIN_SCORE <= 99.
- PLAY -> WON when the incremented score equals WIN_SCORE. This happens in the same register update as the score, so Win and the new ScoreBCD rise together.
- WON:
  - Points are ignored; the score holds.
  - A frame counter counts FrameStart pulses. When it reaches BLINK_FRAMES it resets to 0 and toggles the blank flag.
  - On entry to WON, counter = 0 and blank = 0.
- Clear, any state: score = 00, state = PLAY, lockout = 0, blank = 0, counter = 0. Clear has priority over a simultaneous point.
- Display shadow registers:
  - On a FrameStart cycle, the shadow registers load the glyphs of the score register value present in that cycle, i.e. before any same-cycle increment.
  - While blank = 1, all eight outputs load 0.
  - With LEADING_BLANK = 1 and tens = 0, Tens loads 0.
- Between FrameStart pulses, glyph outputs hold.

## Timing
- Reset values:
  - ScoreBCD = 8'h00, Win = 0, state PLAY, lockout = 0, blank = 0, Point_q = 0.
  - Ones0..3 = 1FF,101,101,1FF (glyph 0).
  - Tens0..3 = 000 when LEADING_BLANK = 1, otherwise glyph 0.
- Point latency: Point low at cycle N-1 and high at N gives ScoreBCD/Win updated after edge N, i.e. visible from cycle N+1.
- Glyph latency: glyphs update after the edge of the first FrameStart cycle at which the new score is registered. Minimum lag from the score change is one cycle; maximum is one frame.
- A point coincident with FrameStart is counted but displayed at the following FrameStart.
- Point held high for many cycles counts once. Re-arming needs Point low for at least one cycle and a FrameStart.
- Reset asserted mid-operation: all state returns to reset values on the next edge, regardless of pending edges or lockout.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- Reset, then a 1-cycle Point pulse followed by FrameStart -> ScoreBCD = 01 one cycle after the pulse. After FrameStart: Ones = 000,102,1FF,100 and Tens = 000.
- Point held high for 100 cycles spanning 3 FrameStarts -> ScoreBCD = 01 only.
- Ten points from 00, each separated by a FrameStart, then one FrameStart -> ScoreBCD = 10, Tens = glyph 1, Ones = 1FF,101,101,1FF.
- WIN_SCORE = 11, score 10, point -> Win = 1 and ScoreBCD = 11 on the same cycle. Further points leave the score at 11. Using BLINK_FRAMES = 2 for this case: after 2 more FrameStart pulses all glyph outputs become 0, and after 2 further pulses they show 11 again.
- Clear and Point rising in the same cycle from score 05 -> ScoreBCD = 00, Win = 0. Glyphs still show 05 until the next FrameStart, then show 00.
- Point rise coincident with FrameStart at score 03 -> ScoreBCD = 04. Glyphs show 03 until the next FrameStart.
